// File: rtl/iter_multiplier_pkg.sv
// Shared M-extension types: operation codes and the multiplier FSM states.
package iter_multiplier_pkg;

  localparam logic [2:0] OPC_MUL    = 3'd0;
  localparam logic [2:0] OPC_MULH   = 3'd1;
  localparam logic [2:0] OPC_MULHSU = 3'd2;
  localparam logic [2:0] OPC_MULHU  = 3'd3;
  localparam logic [2:0] OPC_MULW   = 3'd4;

  typedef enum logic [2:0] {
    OP_MUL    = OPC_MUL,
    OP_MULH   = OPC_MULH,
    OP_MULHSU = OPC_MULHSU,
    OP_MULHU  = OPC_MULHU,
    OP_MULW   = OPC_MULW
  } mul_op_t;

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} mul_state_t;

  // Unassigned encodings 5-7 fall back to MUL.
  function automatic mul_op_t decode_op(input logic [2:0] raw);
    return (raw > OPC_MULW) ? OP_MUL : mul_op_t'(raw);
  endfunction

endpackage

// File: rtl/mul_sign_fix.sv
// Applies the deferred sign to the unsigned magnitude product and picks the
// architectural result field (including MULW sign extension).
module mul_sign_fix
  import iter_multiplier_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic [2*WIDTH-1:0] prod,
  input  logic               negate,
  input  mul_op_t            op,
  output logic [WIDTH-1:0]   result
);

  localparam int HALF = WIDTH / 2;

  logic [2*WIDTH-1:0] fixed;

  always_comb begin
    fixed = negate ? -prod : prod;
    case (op)
      OP_MULH, OP_MULHSU, OP_MULHU: result = fixed[2*WIDTH-1:WIDTH];
      OP_MULW:                      result = {{HALF{fixed[HALF-1]}}, fixed[HALF-1:0]};
      default:                      result = fixed[WIDTH-1:0];
    endcase
  end

endmodule

// File: rtl/iter_multiplier.sv
// Radix-2 shift-add multiplier for RV64M MUL/MULH/MULHSU/MULHU/MULW with
// fixed latency, valid/ready handshakes on both sides and a squash input.
module iter_multiplier
  import iter_multiplier_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result
);

  localparam int HALF  = WIDTH / 2;
  localparam int CNT_W = $clog2(WIDTH + 1);

  mul_state_t         state_q, state_d;
  mul_op_t            op_q, op_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic               neg_q, neg_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               in_ready_q, in_ready_d;
  logic               out_valid_q, out_valid_d;

  mul_op_t          req_op;
  logic             req_w, a_sgn, b_sgn, req_neg;
  logic [WIDTH-1:0] a_ext, b_ext, a_mag, b_mag;

  // Signs are stripped up front so the datapath only ever adds magnitudes.
  always_comb begin
    req_op  = decode_op(op);
    req_w   = (req_op == OP_MULW);
    a_sgn   = (req_op != OP_MULHU);
    b_sgn   = (req_op == OP_MUL) || (req_op == OP_MULH) || req_w;
    a_ext   = req_w ? {{HALF{a[HALF-1]}}, a[HALF-1:0]} : a;
    b_ext   = req_w ? {{HALF{b[HALF-1]}}, b[HALF-1:0]} : b;
    a_mag   = (a_sgn && a_ext[WIDTH-1]) ? -a_ext : a_ext;
    b_mag   = (b_sgn && b_ext[WIDTH-1]) ? -b_ext : b_ext;
    req_neg = (a_sgn & a_ext[WIDTH-1]) ^ (b_sgn & b_ext[WIDTH-1]);
  end

  logic [WIDTH-1:0] addend;
  logic [WIDTH:0]   partial;

  // The multiplier sits in the low half of the accumulator and is consumed
  // one bit per shift; the carry lands in the top bit after the shift.
  always_comb begin
    addend  = acc_q[0] ? mcand_q : '0;
    partial = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, addend};
  end

  // MULW runs half the iterations, leaving the product HALF bits too high.
  logic [2*WIDTH-1:0] prod_aligned;
  logic [WIDTH-1:0]   fix_result;

  assign prod_aligned = (op_q == OP_MULW) ? (acc_q >> HALF) : acc_q;

  mul_sign_fix #(.WIDTH(WIDTH)) u_sign_fix (
    .prod   (prod_aligned),
    .negate (neg_q),
    .op     (op_q),
    .result (fix_result)
  );

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    mcand_d     = mcand_q;
    acc_d       = acc_q;
    neg_d       = neg_q;
    cnt_d       = cnt_q;
    result_d    = result_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;

    case (state_q)
      IDLE: begin
        if (in_valid && !flush) begin
          op_d       = req_op;
          mcand_d    = a_mag;
          acc_d      = {{WIDTH{1'b0}}, b_mag};
          neg_d      = req_neg;
          cnt_d      = req_w ? CNT_W'(HALF) : CNT_W'(WIDTH);
          state_d    = CALC;
          in_ready_d = 1'b0;
        end
      end
      CALC: begin
        acc_d = {partial, acc_q[WIDTH-1:1]};
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = FIX;
      end
      FIX: begin
        result_d    = fix_result;
        out_valid_d = 1'b1;
        state_d     = DONE;
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Squash wins over accept, compute and delivery; result is left as-is.
    if (flush) begin
      state_d     = IDLE;
      out_valid_d = 1'b0;
      in_ready_d  = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      op_q        <= OP_MUL;
      mcand_q     <= '0;
      acc_q       <= '0;
      neg_q       <= 1'b0;
      cnt_q       <= '0;
      result_q    <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      mcand_q     <= mcand_d;
      acc_q       <= acc_d;
      neg_q       <= neg_d;
      cnt_q       <= cnt_d;
      result_q    <= result_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign result    = result_q;

endmodule

// File: doc/iter_multiplier.md
Name: iter_multiplier

Overview:
- Sequential radix-2 shift-add multiplier, one partial product per cycle; companion to the iterative divider in the execute-stage M-extension unit.
- Supports RV64M MUL, MULH, MULHSU, MULHU and MULW.
- Valid/ready handshake on both sides, plus a flush input for pipeline squash.
- Fixed, data-independent latency.

Parameters:
- WIDTH, 64, operand and result width; must be even and at least 8.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  request valid.
- in_ready  out  1  block can accept a request (state IDLE).
- op  in  3  mul_op_t: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 MULW; 5-7 behave as MUL.
- a  in  WIDTH  multiplicand (rs1).
- b  in  WIDTH  multiplier (rs2).
- flush  in  1  abandon any in-flight operation.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- result  out  WIDTH  selected product bits.

Behaviour:
- Reset (rst_n low, asynchronous) forces:
  - state IDLE, in_ready=1, out_valid=0, result=0;
  - internal accumulator, operands and counter cleared.
- Reset mid-operation discards the operation; nothing is emitted.
- States:
  - IDLE: in_ready=1. On in_valid: latch op, operand magnitudes and result-negate flag; load counter; go to CALC.
  - CALC: each edge, if multiplier LSB=1 add multiplicand to the upper half of a 2*WIDTH accumulator, then shift right by 1; decrement counter. When the counter reaches 0, go to FIX.
  - FIX: one edge. Conditionally negate the 2*WIDTH product (two's complement), select the result field into the result register, go to DONE.
  - DONE: out_valid=1, result held stable. On out_ready, go to IDLE.
- Handshake rules:
  - in_ready is deasserted in CALC, FIX and DONE; no back-to-back overlap.
  - out_valid is held with a stable result until out_ready is sampled high.
- Iteration count: WIDTH for full-width ops; WIDTH/2 for MULW.
- Latency from the accept edge to out_valid high:
  - WIDTH+1 cycles for full-width ops (65 at default);
  - WIDTH/2+1 cycles for MULW (33 at default).
- Sign rules:
  - MUL and MULH: both operands signed.
  - MULHSU: a signed, b unsigned.
  - MULHU: both unsigned.
  - MULW: low WIDTH/2 bits of each operand, signed.
  - Signed operands are converted to magnitude; the negate flag is sign(a) XOR sign(b) over the signed operands only.
  - The magnitude of the most-negative value is 2^(WIDTH-1), which fits unsigned and needs no special case.
- Result selection:
  - MUL: product[WIDTH-1:0].
  - MULH, MULHSU, MULHU: product[2*WIDTH-1:WIDTH].
  - MULW: product[WIDTH/2-1:0], sign-extended from bit WIDTH/2-1.
- Zero operands take the full latency; there is no early termination.
- flush:
  - In any state, flush has priority over every other event.
  - The next state is IDLE, out_valid=0, and result is unchanged.
  - If flush and in_valid are both high in IDLE, the request is not accepted.
  - If flush and out_ready are both high in DONE, the result is dropped and the transfer does not count.

Decomposition:
- Shared package (common M-unit package, alongside the divider's types):
  - mul_op_t enum;
  - mul_state_t enum {IDLE, CALC, FIX, DONE};
  - localparam for the op-code values.
- Sub-module: mul_sign_fix, combinational conditional negation plus result-field select and MULW sign-extension. Instantiated once, feeding the FIX register.

Test Plan:
- MULHU, a=b=0xFFFF_FFFF_FFFF_FFFF → result 0xFFFF_FFFF_FFFF_FFFE; out_valid high exactly 65 cycles after accept.
- MUL, a=0xFFFF_FFFF_FFFF_FFFD (-3), b=7 → 0xFFFF_FFFF_FFFF_FFEB. MULH with the same operands → 0xFFFF_FFFF_FFFF_FFFF.
- Signed corner cases:
  - MULH, a=b=0x8000_0000_0000_0000 → 0x4000_0000_0000_0000.
  - MULHSU, a=0xFFFF_FFFF_FFFF_FFFF, b=2 → 0xFFFF_FFFF_FFFF_FFFF.
- MULW, a=0xDEAD_BEEF_7FFF_FFFF, b=2 → 0xFFFF_FFFF_FFFF_FFFE; out_valid 33 cycles after accept.
- Backpressure: out_ready=0 for 10 cycles after out_valid → result stable and in_ready=0 throughout. A new in_valid is ignored until the out_ready handshake completes.
- Flush and reset:
  - flush pulsed 20 cycles into CALC → IDLE next cycle, out_valid never rises. A following request completes with the correct value.
  - rst_n pulsed low mid-CALC (asynchronously, between edges) → immediate IDLE and outputs at reset values.
